branch_pending_tracker: RTL and testbench

Tracks every conditional branch (B instruction) between fetch and in-order resolution. Each fetch group, it packs newly predicted branches into 9-bit global-history entries for the downstream global-history/pending-branch stage. It also keeps an authoritative 20-deep FIFO of predicted directions and converts a resolution mismatch into that stage's recovery command (`passBNum = 7`).

---
 rtl/branch_pending_tracker.sv | 190 +++++++++++++++++++
 tb/tb_branch_pending_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_pending_tracker.sv
// branch_pending_tracker
//
// Tracks conditional branches from fetch until in-order resolution.
// Each fetch group is filtered to the branches that can actually be
// reached under prediction. Those branches are packed into 9-bit
// {hash, predTaken} global-history entries for the GHR stage, and their
// predicted directions are pushed into a circular FIFO of in-flight
// branches. When a resolution disagrees with the FIFO head, the block
// emits a recovery command (passBNum = 7) and flushes the FIFO.
//
// Ports:
//   fire              clock, rising edge
//   rst               synchronous active-low reset
//   i_fetchValid      a fetch group is present this cycle
//   i_brMask_4        per-slot "is a B instruction"; slot 0 is oldest
//   i_predTaken_4     per-slot predicted direction
//   i_pcHash_32       per-slot 8-bit PC hash, slot s at [8s+7:8s]
//   i_resValid        the oldest pending branch resolves this cycle
//   i_resTaken        actual direction of that branch
//   o_newPendingB_8   pending count, or recovery depth when passBNum = 7
//   o_passBNum_3      number of entries to shift in (0..SLOTS), 7 = recover
//   o_newGHREntry_36  packed entries, youngest accepted branch at [8:0]
//   o_stall           previous group was rejected; fetch must replay it
//   o_redirect        one-cycle mispredict pulse
// All outputs are registered (one fire cycle of latency).

module branch_pending_tracker #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned SLOTS = 4
) (
  input  logic                 fire,
  input  logic                 rst,
  input  logic                 i_fetchValid,
  input  logic [SLOTS-1:0]     i_brMask_4,
  input  logic [SLOTS-1:0]     i_predTaken_4,
  input  logic [8*SLOTS-1:0]   i_pcHash_32,
  input  logic                 i_resValid,
  input  logic                 i_resTaken,
  output logic [7:0]           o_newPendingB_8,
  output logic [2:0]           o_passBNum_3,
  output logic [9*SLOTS-1:0]   o_newGHREntry_36,
  output logic                 o_stall,
  output logic                 o_redirect
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = 9 * SLOTS;

  localparam logic [2:0] PassRecover = 3'd7;

  // Circular pointer advance, wrapping DEPTH-1 -> 0.
  function automatic logic [PtrW-1:0] ptrAdd(input logic [PtrW-1:0] ptr,
                                             input logic [2:0]      n);
    int unsigned sum;
    sum = 32'(ptr) + 32'(n);
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PtrW'(sum);
  endfunction

  // State
  logic [DEPTH-1:0] fifoQ, fifoD;
  logic [PtrW-1:0]  rdPtrQ, rdPtrD;
  logic [PtrW-1:0]  wrPtrQ, wrPtrD;
  logic [CntW-1:0]  countQ, countD;

  // Registered outputs
  logic [7:0]       pendQ, pendD;
  logic [2:0]       passQ, passD;
  logic [EntW-1:0]  entryQ, entryD;
  logic             stallQ, stallD;
  logic             redirectQ, redirectD;

  // Group filter
  logic [SLOTS-1:0] accMask;
  logic [2:0]       kCnt;
  logic [EntW-1:0]  groupEntry;
  logic             seenTaken;

  // Resolution / accept
  logic             resActive;
  logic             popOk;
  logic             mispredict;
  logic [CntW-1:0]  afterPop;
  logic [CntW:0]    net;
  logic             accept;
  logic [2:0]       wrIdx;

  // Accept mask slots in program order up to and including the first
  // predicted-taken branch. Each accepted entry is shifted in at the bottom,
  // so the youngest lands in field 0 and the oldest in field k-1.
  always_comb begin
    accMask    = '0;
    kCnt       = '0;
    groupEntry = '0;
    seenTaken  = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (i_fetchValid && i_brMask_4[s] && !seenTaken) begin
        accMask[s] = 1'b1;
        kCnt       = kCnt + 3'd1;
        groupEntry = {groupEntry[EntW-10:0], i_pcHash_32[8*s +: 8], i_predTaken_4[s]};
        if (i_predTaken_4[s]) seenTaken = 1'b1;
      end
    end
  end

  always_comb begin
    resActive  = i_resValid && (countQ != '0);
    popOk      = resActive && (i_resTaken == fifoQ[rdPtrQ]);
    mispredict = resActive && !popOk;
    afterPop   = countQ - CntW'(popOk);
    net        = {1'b0, afterPop} + (CntW+1)'(kCnt);
    accept     = (net <= (CntW+1)'(DEPTH));
  end

  always_comb begin
    fifoD     = fifoQ;
    rdPtrD    = rdPtrQ;
    wrPtrD    = wrPtrQ;
    countD    = countQ;
    pendD     = 8'(countQ);
    passD     = '0;
    entryD    = '0;
    stallD    = 1'b0;
    redirectD = 1'b0;
    wrIdx     = '0;

    if (mispredict) begin
      // Depth reported is the pre-flush count so the GHR stage can unwind
      // back past the mispredicted (oldest) branch; the group is dropped.
      rdPtrD    = '0;
      wrPtrD    = '0;
      countD    = '0;
      pendD     = 8'(countQ);
      passD     = PassRecover;
      redirectD = 1'b1;
    end else begin
      if (popOk) rdPtrD = ptrAdd(rdPtrQ, 3'd1);
      if (accept) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (accMask[s]) begin
            fifoD[ptrAdd(wrPtrQ, wrIdx)] = i_predTaken_4[s];
            wrIdx = wrIdx + 3'd1;
          end
        end
        wrPtrD = ptrAdd(wrPtrQ, kCnt);
        countD = net[CntW-1:0];
        pendD  = 8'(net);
        passD  = kCnt;
        entryD = groupEntry;
      end else begin
        // Overflow: the pop still happens, the group is rejected whole.
        countD = afterPop;
        pendD  = 8'(afterPop);
        stallD = 1'b1;
      end
    end
  end

  always_ff @(posedge fire) begin
    if (!rst) begin
      fifoQ     <= '0;
      rdPtrQ    <= '0;
      wrPtrQ    <= '0;
      countQ    <= '0;
      pendQ     <= '0;
      passQ     <= '0;
      entryQ    <= '0;
      stallQ    <= 1'b0;
      redirectQ <= 1'b0;
    end else begin
      fifoQ     <= fifoD;
      rdPtrQ    <= rdPtrD;
      wrPtrQ    <= wrPtrD;
      countQ    <= countD;
      pendQ     <= pendD;
      passQ     <= passD;
      entryQ    <= entryD;
      stallQ    <= stallD;
      redirectQ <= redirectD;
    end
  end

  assign o_newPendingB_8  = pendQ;
  assign o_passBNum_3     = passQ;
  assign o_newGHREntry_36 = entryQ;
  assign o_stall          = stallQ;
  assign o_redirect       = redirectQ;

endmodule

// File: tb/tb_branch_pending_tracker.sv
module tb_branch_pending_tracker;

  logic        fire = 1'b0;
  logic        rst;
  logic        i_fetchValid;
  logic [3:0]  i_brMask_4;
  logic [3:0]  i_predTaken_4;
  logic [31:0] i_pcHash_32;
  logic        i_resValid;
  logic        i_resTaken;
  logic [7:0]  o_newPendingB_8;
  logic [2:0]  o_passBNum_3;
  logic [35:0] o_newGHREntry_36;
  logic        o_stall;
  logic        o_redirect;

  branch_pending_tracker #(.DEPTH(20), .SLOTS(4)) dut (
    .fire            (fire),
    .rst             (rst),
    .i_fetchValid    (i_fetchValid),
    .i_brMask_4      (i_brMask_4),
    .i_predTaken_4   (i_predTaken_4),
    .i_pcHash_32     (i_pcHash_32),
    .i_resValid      (i_resValid),
    .i_resTaken      (i_resTaken),
    .o_newPendingB_8 (o_newPendingB_8),
    .o_passBNum_3    (o_passBNum_3),
    .o_newGHREntry_36(o_newGHREntry_36),
    .o_stall         (o_stall),
    .o_redirect      (o_redirect)
  );

  always #5 fire = ~fire;

  typedef struct packed {
    logic [2:0]  passB;
    logic [7:0]  pend;
    logic [35:0] entry;
    logic        stall;
    logic        redirect;
  } exp_t;

  exp_t expQ[$];
  bit   modelQ[$];   // predicted bits of in-flight branches, head = oldest
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compareOut(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      chk({tag, ".passB"},    36'(o_passBNum_3),     36'(e.passB));
      chk({tag, ".pendB"},    36'(o_newPendingB_8),  36'(e.pend));
      chk({tag, ".entry"},    o_newGHREntry_36,      e.entry);
      chk({tag, ".stall"},    36'(o_stall),          36'(e.stall));
      chk({tag, ".redirect"}, 36'(o_redirect),       36'(e.redirect));
    end
  endtask

  // One cycle of stimulus: predict from the queue model, drive, clock, compare.
  task automatic step(input logic fv, input logic [3:0] mask, input logic [3:0] pred,
                      input logic [31:0] hash, input logic rv, input logic match,
                      input string tag);
    exp_t e;
    bit   accPred[$];
    logic [7:0] accHash[$];
    logic rt;
    bit   found;
    int   k;
    int   cnt;
    bit   pop;
    bit   mis;
    e = '0;
    found = 0;
    for (int s = 0; s < 4; s++) begin
      if (fv && mask[s] && !found) begin
        accPred.push_back(pred[s]);
        accHash.push_back(hash[8*s +: 8]);
        if (pred[s]) found = 1;
      end
    end
    k = accPred.size();
    cnt = modelQ.size();
    rt = (cnt > 0) ? (match ? modelQ[0] : ~modelQ[0]) : 1'b1;
    pop = rv && cnt > 0 && rt == modelQ[0];
    mis = rv && cnt > 0 && !pop;
    if (mis) begin
      e.passB = 3'd7;
      e.pend = 8'(cnt);
      e.redirect = 1'b1;
      modelQ.delete();
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (modelQ.size() + k <= 20) begin
        // Field j holds the accepted branch k-1-j (field 0 = youngest).
        for (int j = 0; j < k; j++)
          e.entry[9*j +: 9] = {accHash[k-1-j], 1'(accPred[k-1-j])};
        for (int j = 0; j < k; j++) modelQ.push_back(accPred[j]);
        e.passB = 3'(k);
        e.pend = 8'(modelQ.size());
      end else begin
        e.pend = 8'(modelQ.size());
        e.stall = 1'b1;
      end
    end
    expQ.push_back(e);
    rst = 1'b1;
    i_fetchValid = fv;
    i_brMask_4 = mask;
    i_predTaken_4 = pred;
    i_pcHash_32 = hash;
    i_resValid = rv;
    i_resTaken = rt;
    @(posedge fire);
    #1;
    compareOut(tag);
  endtask

  task automatic resetStep(input logic [3:0] mask, input string tag);
    expQ.push_back('0);
    modelQ.delete();
    rst = 1'b0;
    i_fetchValid = 1'b1;
    i_brMask_4 = mask;
    i_predTaken_4 = 4'b0000;
    i_pcHash_32 = 32'hDEADBEEF;
    i_resValid = 1'b1;
    i_resTaken = 1'b1;
    @(posedge fire);
    #1;
    compareOut(tag);
  endtask

  initial begin
    rst = 1'b0;
    i_fetchValid = 1'b0;
    i_brMask_4 = '0;
    i_predTaken_4 = '0;
    i_pcHash_32 = '0;
    i_resValid = 1'b0;
    i_resTaken = 1'b0;
    @(posedge fire);
    #1;
    resetStep(4'b0000, "reset");

    // Filter and packing
    step(1, 4'b0110, 4'b0000, 32'h44332211, 0, 1, "grp0110");
    chk("grp0110.entryConst", o_newGHREntry_36, 36'h8866);
    chk("grp0110.pendConst", 36'(o_newPendingB_8), 36'd2);
    step(1, 4'b1111, 4'b0010, 32'hA3A2A1A0, 0, 1, "grpTaken");
    chk("grpTaken.entryConst", o_newGHREntry_36, 36'h28143);
    chk("grpTaken.passConst", 36'(o_passBNum_3), 36'd2);

    // Drain so that the fill below wraps the pointers
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 4'b0000, 32'h0, 1, 1, "drain");

    step(1, 4'b1111, 4'b0000, 32'h13121110, 0, 1, "fill1");
    step(1, 4'b1111, 4'b1000, 32'h17161514, 0, 1, "fill2");
    step(1, 4'b1111, 4'b0000, 32'h1B1A1918, 0, 1, "fill3");
    step(1, 4'b1111, 4'b1000, 32'h1F1E1D1C, 0, 1, "fill4");
    step(1, 4'b1111, 4'b0000, 32'h23222120, 0, 1, "fill5");
    chk("full.pendConst", 36'(o_newPendingB_8), 36'd20);

    step(1, 4'b0001, 4'b0001, 32'h000000C5, 0, 1, "fullStall");
    chk("fullStall.stallConst", 36'(o_stall), 36'd1);
    step(1, 4'b0001, 4'b0001, 32'h000000C5, 1, 1, "fullPopPush");
    chk("fullPopPush.pendConst", 36'(o_newPendingB_8), 36'd20);
    step(1, 4'b0011, 4'b0000, 32'h0000C7C6, 1, 1, "overPop");
    chk("overPop.pendConst", 36'(o_newPendingB_8), 36'd19);
    step(1, 4'b1111, 4'b0000, 32'h0, 1, 0, "recoverFull");
    step(0, 4'b0000, 4'b0000, 32'h0, 0, 1, "idleAfterFull");

    // Recovery at depth 3
    step(1, 4'b1111, 4'b0000, 32'h33323130, 0, 1, "push4");
    step(1, 4'b0001, 4'b0001, 32'h00000034, 0, 1, "push1");
    step(0, 4'b0000, 4'b0000, 32'h0, 1, 1, "res1");
    step(0, 4'b0000, 4'b0000, 32'h0, 1, 1, "res2");
    step(1, 4'b0111, 4'b0000, 32'h00525150, 1, 0, "mispred");
    chk("mispred.passConst", 36'(o_passBNum_3), 36'd7);
    chk("mispred.pendConst", 36'(o_newPendingB_8), 36'd3);
    step(0, 4'b0000, 4'b0000, 32'h0, 0, 1, "postRecover");
    chk("postRecover.pendConst", 36'(o_newPendingB_8), 36'd0);

    step(0, 4'b0000, 4'b0000, 32'h0, 1, 1, "resEmpty");
    step(0, 4'b1111, 4'b1111, 32'hFFFFFFFF, 0, 1, "fetchInvalid");
    step(1, 4'b1010, 4'b1000, 32'h66554433, 0, 1, "gapMask");

    // Reset mid-stream at count 7
    resetStep(4'b0000, "preReset.clear");
    step(1, 4'b1111, 4'b0000, 32'h43424140, 0, 1, "r4");
    step(1, 4'b0111, 4'b0100, 32'h00464544, 0, 1, "r3");
    chk("r3.pendConst", 36'(o_newPendingB_8), 36'd7);
    resetStep(4'b1111, "midReset");
    step(1, 4'b0011, 4'b0000, 32'h00004847, 0, 1, "afterReset");
    chk("afterReset.pendConst", 36'(o_newPendingB_8), 36'd2);

    for (int i = 0; i < 60; i++)
      step(1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom),
           ($urandom_range(0, 7) != 0), "rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
